// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, memory req/gnt/rvalid handshake, store lane encoding, load extraction and writeback.
// Latency: wb_en three cycles after acceptance at best; ex_ready only while IDLE, so the execute stage stalls on busy.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_f3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_val,
  output logic        busy,
  output logic        err_misalign,
  output logic        err_bus,
  output logic [31:0] err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          is_load_q, is_load_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [4:0]    rd_q, rd_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          wb_en_q, wb_en_d;
  logic [4:0]    wb_reg_q, wb_reg_d;
  logic [31:0]   wb_val_q, wb_val_d;
  logic          err_mis_q, err_mis_d;
  logic          err_bus_q, err_bus_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic          op_legal;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;

  // Both load and store set at once is treated as an illegal op.
  always_comb begin
    op_legal = 1'b0;
    case (ex_f3)
      3'b000:  op_legal = 1'b1;
      3'b001:  op_legal = ~ex_addr[0];
      3'b010:  op_legal = (ex_addr[1:0] == 2'b00);
      3'b100:  op_legal = ex_load;
      3'b101:  op_legal = ex_load & ~ex_addr[0];
      default: op_legal = 1'b0;
    endcase
    if (ex_load && ex_store) op_legal = 1'b0;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_f3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
      end
    endcase
    if (ex_load) begin
      st_be    = 4'b0000;
      st_wdata = 32'd0;
    end
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_load_q  <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      rd_q       <= 5'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      wb_en_q    <= 1'b0;
      wb_reg_q   <= 5'd0;
      wb_val_q   <= 32'd0;
      err_mis_q  <= 1'b0;
      err_bus_q  <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_load_q  <= is_load_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_en_q    <= wb_en_d;
      wb_reg_q   <= wb_reg_d;
      wb_val_q   <= wb_val_d;
      err_mis_q  <= err_mis_d;
      err_bus_q  <= err_bus_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_load_d  = is_load_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_en_d    = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_val_d   = wb_val_q;
    err_mis_d  = 1'b0;
    err_bus_d  = 1'b0;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && (ex_load || ex_store)) begin
          if (op_legal) begin
            is_load_d = ex_load;
            f3_d      = ex_f3;
            addr_d    = ex_addr;
            rd_d      = ex_rd;
            be_d      = st_be;
            wdata_d   = st_wdata;
            state_d   = S_REQ;
          end else begin
            err_mis_d  = 1'b1;
            err_addr_d = ex_addr;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response in the final cycle still beats the timeout.
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (is_load_q && (rd_q != 5'd0)) begin
            wb_en_d  = 1'b1;
            wb_reg_d = rd_q;
            wb_val_d = ld_val;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          err_bus_d  = 1'b1;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex_ready     = (state_q == S_IDLE);
    busy         = ~ex_ready;
    mem_req      = (state_q == S_REQ);
    mem_we       = mem_req & ~is_load_q;
    mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be       = mem_req ? be_q : 4'd0;
    mem_wdata    = mem_req ? wdata_q : 32'd0;
    wb_en        = wb_en_q;
    wb_reg       = wb_reg_q;
    wb_val       = wb_val_q;
    err_misalign = err_mis_q;
    err_bus      = err_bus_q;
    err_addr     = err_addr_q;
  end

endmodule
